// File: rtl/mmss_timer_ctrl.sv
// MM:SS countdown controller feeding the minute/second fields of the 7-segment driver.
// Optional button debounce filter is compiled in with `define DEBOUNCE_EN.

// Button conditioner: 2-flop synchronizer, optional counter filter, rising-edge pulse.
module mmss_btn_cond
`ifdef DEBOUNCE_EN
#(
    parameter int unsigned DEB_CYCLES = 1_000_000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          filt;

    // Filtered level follows the synchronized input only after a full run of
    // DEB_CYCLES samples that disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            filt <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_prev <= 1'b0;
        else        level_prev <= level;
    end

    assign pulse = level & ~level_prev;

endmodule

module mmss_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100_000_000
`ifdef DEBOUNCE_EN
   ,parameter int unsigned DEB_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [6:0] load_min,
    input  logic [6:0] load_sec,
    output logic [6:0] num21,
    output logic [6:0] num22,
    output logic [1:0] state,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t          cur;
    state_t          nxt;
    logic [6:0]      min_q;
    logic [6:0]      sec_q;
    logic [PW-1:0]   pre;
    logic            done_q;
    logic [6:0]      min_n;
    logic [6:0]      sec_n;
    logic [PW-1:0]   pre_n;
    logic            done_n;
    logic [1:0]      btn_raw;
    logic [1:0]      btn_pulse;
    logic            start_p;
    logic            pause_p;
    logic [6:0]      min_c;
    logic [6:0]      sec_c;
    logic            load_zero;
    logic            tick;
    logic            last_sec;

    assign btn_raw = {btn_pause, btn_start};

    for (genvar i = 0; i < 2; i++) begin : g_btn
`ifdef DEBOUNCE_EN
        mmss_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
`else
        mmss_btn_cond u_cond (
`endif
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .pulse (btn_pulse[i])
        );
    end

    // Start has priority: a pause arriving in the same cycle is dropped.
    assign start_p = btn_pulse[0];
    assign pause_p = btn_pulse[1] & ~start_p;

    assign min_c     = (load_min > 7'd99) ? 7'd99 : load_min;
    assign sec_c     = (load_sec > 7'd59) ? 7'd59 : load_sec;
    assign load_zero = (min_c == 7'd0) && (sec_c == 7'd0);
    assign tick      = (cur == RUN) && (pre == PRE_LAST);
    assign last_sec  = (min_q == 7'd0) && (sec_q == 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE: begin
                if (start_p) nxt = load_zero ? DONE : RUN;
            end
            RUN: begin
                if (start_p)              nxt = load_zero ? DONE : RUN;
                else if (pause_p)         nxt = PAUSE;
                else if (tick && last_sec) nxt = DONE;
            end
            PAUSE: begin
                if (start_p)      nxt = load_zero ? DONE : RUN;
                else if (pause_p) nxt = RUN;
            end
            DONE: begin
                if (start_p) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Datapath next values; a reload overrides whatever the current state would do.
    always_comb begin
        min_n  = min_q;
        sec_n  = sec_q;
        pre_n  = pre;
        unique case (cur)
            IDLE: begin
                min_n = min_c;
                sec_n = sec_c;
                pre_n = '0;
            end
            RUN: begin
                if (!start_p && !pause_p) begin
                    pre_n = tick ? '0 : pre + PW'(1);
                    if (tick) begin
                        if (sec_q != 7'd0) begin
                            sec_n = sec_q - 7'd1;
                        end else begin
                            min_n = min_q - 7'd1;
                            sec_n = 7'd59;
                        end
                    end
                end
            end
            PAUSE: begin
                pre_n = pre;
            end
            DONE: begin
                min_n = 7'd0;
                sec_n = 7'd0;
                pre_n = '0;
            end
            default: begin
                min_n = 7'd0;
                sec_n = 7'd0;
                pre_n = '0;
            end
        endcase
        if (start_p && (cur != DONE)) begin
            min_n = min_c;
            sec_n = sec_c;
            pre_n = '0;
        end
        done_n = (nxt == DONE) && (cur != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q  <= 7'd0;
            sec_q  <= 7'd0;
            pre    <= '0;
            done_q <= 1'b0;
        end else begin
            min_q  <= min_n;
            sec_q  <= sec_n;
            pre    <= pre_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        alarm = (cur == DONE);
        state = cur;
        num21 = min_q;
        num22 = sec_q;
        done  = done_q;
    end

endmodule
